// File: rtl/bp_sched_pkg.sv
// rtl/bp_sched_pkg.sv - shared constants, FSM state type and decoder bit order for the BP frame scheduler
package bp_sched_pkg;

  // Default LLR sample width and the (8,4) code geometry
  localparam int LLR_W = 8;
  localparam int N     = 8;
  localparam int K     = 4;
  localparam int IDX_W = $clog2(N);

  // Position of each decoder output bit inside the dec_out bus {OUT_8, OUT_7, OUT_6, OUT_4}
  localparam int OUT4_POS = 0;
  localparam int OUT6_POS = 1;
  localparam int OUT7_POS = 2;
  localparam int OUT8_POS = 3;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    DECODE,
    RESULT
  } state_t;

  // Message bits are the systematic positions OUT_4, OUT_6, OUT_7, OUT_8, LSB first
  function automatic logic [K-1:0] msg_from_dec(input logic [K-1:0] d);
    logic [K-1:0] m;
    m    = '0;
    m[0] = d[OUT4_POS];
    m[1] = d[OUT6_POS];
    m[2] = d[OUT7_POS];
    m[3] = d[OUT8_POS];
    return m;
  endfunction

endpackage

// File: rtl/bp_llr_pingpong.sv
// rtl/bp_llr_pingpong.sv - two-frame LLR store with sof alignment, full flags and in-order read select
module bp_llr_pingpong #(
  parameter int LLR_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_wr_en,
  input  logic [LLR_W-1:0]               i_wr_data,
  input  logic                           i_wr_sof,
  input  logic                           i_release,
  output logic                           o_wr_ready,
  output logic                           o_cur_full,
  output logic                           o_nxt_full,
  output logic [bp_sched_pkg::N*LLR_W-1:0] o_cur_frame,
  output logic [bp_sched_pkg::N*LLR_W-1:0] o_nxt_frame,
  output logic [7:0]                     o_sync_err_cnt
);
  import bp_sched_pkg::*;

  logic [LLR_W-1:0] r_mem [2][N];
  logic [1:0]       r_full;
  logic             r_wr_buf;
  logic             r_rd_buf;
  logic [IDX_W-1:0] r_wr_idx;
  logic [7:0]       r_sync_err;

  logic             w_sync_restart;
  logic             w_drop;
  logic             w_store;
  logic             w_last;
  logic [IDX_W-1:0] w_slot;

  // Fill and drain alternate between the two buffers, so the one being filled is
  // only ever full when both are; stall the stream exactly then.
  assign o_wr_ready     = ~(r_full[0] & r_full[1]);
  assign o_cur_full     = r_full[r_rd_buf];
  assign o_nxt_full     = r_full[~r_rd_buf];
  assign o_sync_err_cnt = r_sync_err;

  // Classify each accepted byte: realign on early sof, drop unaligned bytes, else store
  always_comb begin
    w_sync_restart = i_wr_en & i_wr_sof & (r_wr_idx != '0);
    w_drop         = i_wr_en & ~i_wr_sof & (r_wr_idx == '0);
    w_store        = i_wr_en & ~w_drop;
    w_slot         = w_sync_restart ? '0 : r_wr_idx;
    w_last         = w_store & (w_slot == IDX_W'(N - 1));
  end

  // Buffer bookkeeping: release clears before a completion sets, so free-then-write holds
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full     <= '0;
      r_wr_buf   <= 1'b0;
      r_rd_buf   <= 1'b0;
      r_wr_idx   <= '0;
      r_sync_err <= '0;
    end else begin
      if (i_release) begin
        r_full[r_rd_buf] <= 1'b0;
        r_rd_buf         <= ~r_rd_buf;
      end
      if (w_store) begin
        if (w_last) begin
          r_full[r_wr_buf] <= 1'b1;
          r_wr_buf         <= ~r_wr_buf;
          r_wr_idx         <= '0;
        end else begin
          r_wr_idx <= w_slot + 1'b1;
        end
      end
      if (w_sync_restart && (r_sync_err != 8'hFF)) begin
        r_sync_err <= r_sync_err + 8'd1;
      end
    end
  end

  // LLR sample storage; contents are only meaningful once the full flag is set
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_buf][w_slot] <= i_wr_data;
    end
  end

  // Present the oldest frame and the one queued behind it, LLR_1 in the LSBs
  always_comb begin
    o_cur_frame = '0;
    o_nxt_frame = '0;
    for (int i = 0; i < N; i++) begin
      o_cur_frame[i*LLR_W +: LLR_W] = r_mem[r_rd_buf][i];
      o_nxt_frame[i*LLR_W +: LLR_W] = r_mem[~r_rd_buf][i];
    end
  end

endmodule

// File: rtl/bp_frame_sched.sv
// rtl/bp_frame_sched.sv - schedules buffered LLR frames through a bp_8_4 decoder and returns results
module bp_frame_sched #(
  parameter int LLR_W     = bp_sched_pkg::LLR_W,
  parameter int BUSY_WAIT = 4,
  parameter int DEC_TMO   = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LLR_W-1:0]   llr_data,
  input  logic               llr_valid,
  output logic               llr_ready,
  input  logic               llr_sof,
  output logic               dec_start_n,
  input  logic               dec_busy,
  output logic [8*LLR_W-1:0] dec_llr,
  input  logic [3:0]         dec_out,
  output logic [3:0]         res_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_err,
  output logic [7:0]         res_id,
  output logic [7:0]         sync_err_cnt
);
  import bp_sched_pkg::*;

  localparam int CNT_W = 16;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [N*LLR_W-1:0] r_dec_llr;
  logic [K-1:0]       r_res_data;
  logic               r_res_err;
  logic [7:0]         r_res_id;

  logic               w_accept;
  logic               w_release;
  logic               w_load;
  logic               w_wr_ready;
  logic               w_cur_full;
  logic               w_nxt_full;
  logic [N*LLR_W-1:0] w_cur_frame;
  logic [N*LLR_W-1:0] w_nxt_frame;

  assign w_accept  = llr_valid & w_wr_ready;
  assign w_release = (r_state == RESULT) & res_ready;
  // A frame is copied to the decoder on every entry into LAUNCH
  assign w_load    = ((r_state == IDLE) & w_cur_full) | (w_release & w_nxt_full);

  assign llr_ready = w_wr_ready;
  assign dec_llr   = r_dec_llr;
  assign res_data  = r_res_data;
  assign res_err   = r_res_err;
  assign res_id    = r_res_id;

  bp_llr_pingpong #(
    .LLR_W (LLR_W)
  ) u_store (
    .clk            (clk),
    .rst            (rst),
    .i_wr_en        (w_accept),
    .i_wr_data      (llr_data),
    .i_wr_sof       (llr_sof),
    .i_release      (w_release),
    .o_wr_ready     (w_wr_ready),
    .o_cur_full     (w_cur_full),
    .o_nxt_full     (w_nxt_full),
    .o_cur_frame    (w_cur_frame),
    .o_nxt_frame    (w_nxt_frame),
    .o_sync_err_cnt (sync_err_cnt)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state: launch, wait for busy, wait for done, hold result until taken
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_cur_full) w_next = LAUNCH;
      end
      LAUNCH: begin
        w_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (dec_busy) begin
          w_next = DECODE;
        end else if (r_cnt == CNT_W'(BUSY_WAIT - 1)) begin
          w_next = RESULT;
        end
      end
      DECODE: begin
        if (!dec_busy || (r_cnt == CNT_W'(DEC_TMO - 1))) w_next = RESULT;
      end
      RESULT: begin
        if (res_ready) w_next = w_nxt_full ? LAUNCH : IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // FSM outputs: one-cycle active-low start in LAUNCH, result valid while in RESULT
  always_comb begin
    dec_start_n = 1'b1;
    res_valid   = 1'b0;
    if (r_state == LAUNCH) dec_start_n = 1'b0;
    if (r_state == RESULT) res_valid = 1'b1;
  end

  // Datapath: per-state cycle counter, decoder input latch, result capture and sequence id
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_dec_llr  <= '0;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
      r_res_id   <= '0;
    end else begin
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      if (w_load) begin
        r_dec_llr <= (r_state == RESULT) ? w_nxt_frame : w_cur_frame;
      end
      if ((r_state == WAIT_BUSY) && (w_next == RESULT)) begin
        r_res_data <= '0;
        r_res_err  <= 1'b1;
      end
      if ((r_state == DECODE) && (w_next == RESULT)) begin
        if (!dec_busy) begin
          r_res_data <= msg_from_dec(dec_out);
          r_res_err  <= 1'b0;
        end else begin
          r_res_data <= '0;
          r_res_err  <= 1'b1;
        end
      end
      if (w_release) begin
        r_res_id <= r_res_id + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bp_frame_sched.sv
// tb/tb_bp_frame_sched.sv - directed self-checking bench for bp_frame_sched
module tb_bp_frame_sched;

  logic        clk;
  logic        rst;
  logic [7:0]  llr_data;
  logic        llr_valid;
  logic        llr_ready;
  logic        llr_sof;
  logic        dec_start_n;
  logic        dec_busy;
  logic [63:0] dec_llr;
  logic [3:0]  dec_out;
  logic [3:0]  res_data;
  logic        res_valid;
  logic        res_ready;
  logic        res_err;
  logic [7:0]  res_id;
  logic [7:0]  sync_err_cnt;

  int errors = 0;
  int checks = 0;

  int m_mode     = 0;
  int m_busy_len = 6;
  int bcnt       = 0;

  int start_cnt  = 0;
  int run        = 0;
  int max_run    = 0;
  int valid_seen = 0;

  typedef struct {
    logic [7:0]  id;
    logic        err;
    logic [3:0]  data;
    logic [63:0] llr;
  } rec_t;
  rec_t rq[$];

  bp_frame_sched #(
    .LLR_W     (8),
    .BUSY_WAIT (4),
    .DEC_TMO   (255)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .llr_data     (llr_data),
    .llr_valid    (llr_valid),
    .llr_ready    (llr_ready),
    .llr_sof      (llr_sof),
    .dec_start_n  (dec_start_n),
    .dec_busy     (dec_busy),
    .dec_llr      (dec_llr),
    .dec_out      (dec_out),
    .res_data     (res_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_err      (res_err),
    .res_id       (res_id),
    .sync_err_cnt (sync_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder model: mode 0 busy for m_busy_len cycles, 1 never busy, 2 busy stuck high
  initial begin
    logic s;
    dec_busy = 1'b0;
    forever begin
      @(posedge clk);
      s = dec_start_n;
      #1;
      if (m_mode == 2 && !s) begin
        dec_busy = 1'b1;
      end else if (m_mode == 0 && !s) begin
        dec_busy = 1'b1;
        bcnt     = m_busy_len;
      end else if (bcnt > 0) begin
        bcnt = bcnt - 1;
        if (bcnt == 0) dec_busy = 1'b0;
      end else if (m_mode != 2) begin
        dec_busy = 1'b0;
      end
    end
  end

  // Monitor: start-pulse count and width, result-valid cycles, accepted results
  always @(posedge clk) begin
    rec_t r;
    if (!rst && dec_start_n === 1'b0) begin
      start_cnt = start_cnt + 1;
      run       = run + 1;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (res_valid === 1'b1) valid_seen = valid_seen + 1;
    if (!rst && res_valid === 1'b1 && res_ready === 1'b1) begin
      r.id   = res_id;
      r.err  = res_err;
      r.data = res_data;
      r.llr  = dec_llr;
      rq.push_back(r);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s);
    int w;
    w         = 0;
    llr_data  = d;
    llr_sof   = s;
    llr_valid = 1'b1;
    while (llr_ready !== 1'b1 && w < 200) begin
      tick;
      w++;
    end
    if (w >= 200) chk("send_byte_timeout", llr_ready, 1);
    tick;
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 0; i < 8; i++) send_byte(f[i*8 +: 8], (i == 0));
    llr_valid = 1'b0;
    llr_sof   = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < 400) begin
      tick;
      n++;
    end
  endtask

  task automatic ack;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_llr_ready"}, llr_ready, 1);
    chk({tag, "_start_n"}, dec_start_n, 1);
    chk({tag, "_dec_llr"}, dec_llr, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_err"}, res_err, 0);
    chk({tag, "_res_id"}, res_id, 0);
    chk({tag, "_sync_err"}, sync_err_cnt, 0);
  endtask

  initial begin
    int          n;
    int          w;
    int          s0;
    int          v0;
    int          bad;
    logic [7:0]  b;
    logic [63:0] exp3 [3];

    rst       = 1'b1;
    llr_data  = '0;
    llr_valid = 1'b0;
    llr_sof   = 1'b0;
    res_ready = 1'b0;
    dec_out   = 4'b1010;
    repeat (3) tick;
    chk_reset_state("reset");
    rst = 1'b0;
    tick;

    // Basic frame, 6-cycle decoder busy, OUT=1010
    s0 = start_cnt;
    send_frame(64'hFFFF_0101_0100_FFFF);
    wait_valid(n);
    chk("t1_valid", res_valid, 1);
    chk("t1_latency", n, 9);
    chk("t1_data", res_data, 4'hA);
    chk("t1_err", res_err, 0);
    chk("t1_id", res_id, 0);
    chk("t1_dec_llr", dec_llr, 64'hFFFF_0101_0100_FFFF);
    chk("t1_starts", start_cnt - s0, 1);
    chk("t1_start_width", max_run, 1);
    ack;
    chk("t1_valid_cleared", res_valid, 0);
    chk("t1_id_incr", res_id, 1);

    // Unaligned byte dropped, then early sof realigns the frame
    s0 = start_cnt;
    send_byte(8'h55, 1'b0);
    chk("t2_drop_no_err", sync_err_cnt, 0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    chk("t2_partial_no_err", sync_err_cnt, 0);
    send_frame(64'h0807_0605_0403_0201);
    chk("t2_sync_err", sync_err_cnt, 1);
    wait_valid(n);
    chk("t2_valid", res_valid, 1);
    chk("t2_dec_llr", dec_llr, 64'h0807_0605_0403_0201);
    chk("t2_data", res_data, 4'hA);
    chk("t2_id", res_id, 1);
    chk("t2_starts", start_cnt - s0, 1);
    ack;

    // Three back-to-back frames under result backpressure
    rq.delete();
    s0 = start_cnt;
    exp3[0] = 64'h1716_1514_1312_1110;
    exp3[1] = 64'h2726_2524_2322_2120;
    exp3[2] = 64'h3736_3534_3332_3130;
    send_frame(exp3[0]);
    chk("t3_ready_after_a", llr_ready, 1);
    send_frame(exp3[1]);
    chk("t3_ready_after_b", llr_ready, 0);
    llr_data  = 8'h30;
    llr_sof   = 1'b1;
    llr_valid = 1'b1;
    repeat (40) tick;
    chk("t3_ready_held", llr_ready, 0);
    chk("t3_valid_held", res_valid, 1);
    chk("t3_id_held", res_id, 2);
    chk("t3_none_taken", rq.size(), 0);
    res_ready = 1'b1;
    send_frame(exp3[2]);
    w = 0;
    while (rq.size() < 3 && w < 300) begin
      tick;
      w++;
    end
    chk("t3_count", rq.size(), 3);
    if (rq.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t3_id_%0d", i), rq[i].id, 2 + i);
        chk($sformatf("t3_llr_%0d", i), rq[i].llr, exp3[i]);
        chk($sformatf("t3_data_%0d", i), rq[i].data, 4'hA);
        chk($sformatf("t3_err_%0d", i), rq[i].err, 0);
      end
    end
    res_ready = 1'b0;
    chk("t3_starts", start_cnt - s0, 3);
    chk("t3_id_after", res_id, 5);

    // Decoder never raises busy
    m_mode = 1;
    s0 = start_cnt;
    send_frame(64'h4746_4544_4342_4140);
    wait_valid(n);
    chk("t4_nobusy_latency", n, 6);
    chk("t4_nobusy_err", res_err, 1);
    chk("t4_nobusy_data", res_data, 0);
    chk("t4_nobusy_id", res_id, 5);
    chk("t4_nobusy_starts", start_cnt - s0, 1);
    ack;

    // Decoder busy stuck high
    m_mode = 2;
    send_frame(64'h5756_5554_5352_5150);
    wait_valid(n);
    chk("t4_stuck_latency", n, 258);
    chk("t4_stuck_err", res_err, 1);
    chk("t4_stuck_data", res_data, 0);
    chk("t4_stuck_id", res_id, 6);
    m_mode = 0;
    ack;
    chk("t4_id_after", res_id, 7);

    // Reset during DECODE abandons the frame
    m_busy_len = 6;
    v0 = valid_seen;
    send_frame(64'h6766_6564_6362_6160);
    repeat (5) tick;
    chk("t5_no_valid_yet", res_valid, 0);
    rst = 1'b1;
    tick;
    chk_reset_state("t5_rst");
    rst = 1'b0;
    s0 = start_cnt;
    repeat (30) tick;
    chk("t5_no_start", start_cnt - s0, 0);
    chk("t5_never_valid", valid_seen - v0, 0);

    // 256 frames: res_id wraps 255 -> 0
    m_busy_len = 2;
    rq.delete();
    res_ready = 1'b1;
    for (int f = 0; f < 256; f++) begin
      b = 8'(f);
      send_frame({8{b}});
    end
    w = 0;
    while (rq.size() < 256 && w < 2000) begin
      tick;
      w++;
    end
    res_ready = 1'b0;
    chk("t6_count", rq.size(), 256);
    bad = 0;
    for (int i = 0; i < rq.size(); i++) begin
      if (rq[i].id !== 8'(i) || rq[i].err !== 1'b0 || rq[i].llr !== {8{8'(i)}}) bad++;
    end
    chk("t6_order", bad, 0);
    chk("t6_wrap_id", res_id, 0);
    chk("t6_start_width", max_run, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
